// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction-fetch stage and the instruction ROM.
package fetch_pkg;

    // Encoding loaded into empty pipeline slots.
    localparam logic [31:0] NOP_INSTR = 32'hD503201F;

    // ROM size in bytes; the ROM instance uses the same value.
    localparam int IMEM_SIZE_DEFAULT = 1024;

    typedef enum logic {
        FETCH  = 1'b0,
        HALTED = 1'b1
    } fetch_state_t;

    // True when a word fetch at addr stays inside the ROM.
    // Comparing against the last word address avoids an overflowing add.
    function automatic logic addr_in_rom(input logic [63:0] addr,
                                         input logic [63:0] last_word_addr);
        return addr <= last_word_addr;
    endfunction

endpackage

// File: rtl/if_id_reg.sv
// Pipeline register with hold and bubble-insert controls.
// Priority: reset > flush > hold > load.
module if_id_reg
    import fetch_pkg::*;
#(
    parameter int          INSTR_W      = 32,
    parameter int          PC_W         = 64,
    parameter logic [31:0] BUBBLE_INSTR = NOP_INSTR
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               hold,
    input  logic               flush,
    input  logic               load_valid,
    input  logic [INSTR_W-1:0] load_instr,
    input  logic [PC_W-1:0]    load_pc,
    input  logic [PC_W-1:0]    load_pc_plus4,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc,
    output logic [PC_W-1:0]    pc_plus4
);

    // Register update: a bubble on reset or flush, unchanged on hold, else capture.
    always_ff @(posedge clk) begin
        if (!reset_n || flush) begin
            valid    <= 1'b0;
            instr    <= INSTR_W'(BUBBLE_INSTR);
            pc       <= '0;
            pc_plus4 <= '0;
        end else if (!hold) begin
            valid    <= load_valid;
            instr    <= load_instr;
            pc       <= load_pc;
            pc_plus4 <= load_pc_plus4;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection, ROM bounds check,
// FETCH/HALTED state, and the IF/ID pipeline register.
module fetch_stage
    import fetch_pkg::*;
#(
    parameter int          IMEM_SIZE = IMEM_SIZE_DEFAULT,
    parameter logic [63:0] RESET_PC  = 64'd0
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic [63:0] imem_addr,
    input  logic [31:0] imem_instr,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [63:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_instr,
    output logic [63:0] if_id_pc,
    output logic [63:0] if_id_pc_plus4,
    output logic        halted
);

    localparam logic [63:0] LAST_WORD_ADDR = 64'(IMEM_SIZE) - 64'd4;

    fetch_state_t state;
    logic [63:0]  pc;
    logic [63:0]  pc_plus4;
    logic [63:0]  redirect_target;
    logic         pc_in_rom;
    logic         next_in_rom;
    logic         target_in_rom;
    logic         capture;
    logic         reg_flush;
    logic         reg_hold;

    // Datapath helpers: incremented PC, aligned redirect target, and bounds checks.
    always_comb begin
        pc_plus4        = pc + 64'd4;
        redirect_target = redirect_pc & ~64'd3;
        pc_in_rom       = addr_in_rom(pc, LAST_WORD_ADDR);
        next_in_rom     = addr_in_rom(pc_plus4, LAST_WORD_ADDR);
        target_in_rom   = addr_in_rom(redirect_target, LAST_WORD_ADDR);
    end

    // IF/ID control: squash on redirect, bubble when there is nothing valid to capture.
    always_comb begin
        capture   = (state == FETCH) && pc_in_rom;
        reg_flush = redirect_i || (!stall_i && !capture);
        reg_hold  = stall_i && !redirect_i;
    end

    // PC and state register, priority reset > redirect > stall > advance.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            state  <= FETCH;
            halted <= 1'b0;
        end else if (redirect_i) begin
            pc     <= redirect_target;
            state  <= target_in_rom ? FETCH : HALTED;
            halted <= !target_in_rom;
        end else if (!stall_i) begin
            case (state)
                FETCH: begin
                    if (pc_in_rom) begin
                        pc <= pc_plus4;
                        if (!next_in_rom) begin
                            state  <= HALTED;
                            halted <= 1'b1;
                        end
                    end else begin
                        state  <= HALTED;
                        halted <= 1'b1;
                    end
                end
                HALTED: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
                default: begin
                    state  <= HALTED;
                    halted <= 1'b1;
                end
            endcase
        end
    end

    assign imem_addr = pc;

    if_id_reg #(
        .INSTR_W      (32),
        .PC_W         (64),
        .BUBBLE_INSTR (NOP_INSTR)
    ) u_if_id_reg (
        .clk           (clk),
        .reset_n       (reset_n),
        .hold          (reg_hold),
        .flush         (reg_flush),
        .load_valid    (1'b1),
        .load_instr    (imem_instr),
        .load_pc       (pc),
        .load_pc_plus4 (pc_plus4),
        .valid         (if_id_valid),
        .instr         (if_id_instr),
        .pc            (if_id_pc),
        .pc_plus4      (if_id_pc_plus4)
    );

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a table of per-cycle vectors plus
// hand-written sequences for the run-off-the-end and reset cases.
module tb_fetch_stage;

    localparam logic [31:0] NOP = 32'hD503201F;

    logic        clk;
    logic        reset_n;
    logic [63:0] imem_addr;
    logic [31:0] imem_instr;
    logic        stall_i;
    logic        redirect_i;
    logic [63:0] redirect_pc;
    logic        if_id_valid;
    logic [31:0] if_id_instr;
    logic [63:0] if_id_pc;
    logic [63:0] if_id_pc_plus4;
    logic        halted;

    int errors = 0;
    int checks = 0;

    typedef struct {
        logic        rst_n;
        logic        stall;
        logic        redirect;
        logic [63:0] rpc;
        logic        e_valid;
        logic [31:0] e_instr;
        logic [63:0] e_pc;
        logic        e_halted;
        logic [63:0] e_addr;
    } vec_t;

    localparam int NVEC = 20;
    vec_t vecs[NVEC];

    fetch_stage #(
        .IMEM_SIZE (1024),
        .RESET_PC  (64'd0)
    ) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_addr      (imem_addr),
        .imem_instr     (imem_instr),
        .stall_i        (stall_i),
        .redirect_i     (redirect_i),
        .redirect_pc    (redirect_pc),
        .if_id_valid    (if_id_valid),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus4 (if_id_pc_plus4),
        .halted         (halted)
    );

    // ROM model: word i holds i+1.
    assign imem_instr = 32'(imem_addr >> 2) + 32'd1;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst_n, logic stall, logic redirect, logic [63:0] rpc,
                                logic e_valid, logic [31:0] e_instr, logic [63:0] e_pc,
                                logic e_halted, logic [63:0] e_addr);
        vec_t v;
        v.rst_n = rst_n; v.stall = stall; v.redirect = redirect; v.rpc = rpc;
        v.e_valid = e_valid; v.e_instr = e_instr; v.e_pc = e_pc;
        v.e_halted = e_halted; v.e_addr = e_addr;
        return v;
    endfunction

    task automatic checkField(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input logic rst_n, input logic stall, input logic redirect,
                                 input logic [63:0] rpc);
        reset_n     = rst_n;
        stall_i     = stall;
        redirect_i  = redirect;
        redirect_pc = rpc;
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input logic e_valid, input logic [31:0] e_instr,
                               input logic [63:0] e_pc, input logic e_halted,
                               input logic [63:0] e_addr);
        checkField({tag, ".valid"}, 64'(if_id_valid), 64'(e_valid));
        checkField({tag, ".instr"}, 64'(if_id_instr), 64'(e_instr));
        checkField({tag, ".halted"}, 64'(halted), 64'(e_halted));
        checkField({tag, ".imem_addr"}, imem_addr, e_addr);
        if (e_valid) begin
            checkField({tag, ".pc"}, if_id_pc, e_pc);
            checkField({tag, ".pc_plus4"}, if_id_pc_plus4, e_pc + 64'd4);
        end
    endtask

    initial begin
        reset_n     = 1'b0;
        stall_i     = 1'b0;
        redirect_i  = 1'b0;
        redirect_pc = 64'd0;

        //              rst stl red rpc          valid instr  pc      halt addr
        vecs[0]  = mk(0, 0, 0, 64'h0,    0, NOP,   64'h0,   0, 64'h0);
        vecs[1]  = mk(1, 0, 0, 64'h0,    1, 32'd1, 64'h0,   0, 64'h4);
        vecs[2]  = mk(1, 0, 0, 64'h0,    1, 32'd2, 64'h4,   0, 64'h8);
        vecs[3]  = mk(1, 1, 0, 64'h0,    1, 32'd2, 64'h4,   0, 64'h8);
        vecs[4]  = mk(1, 1, 0, 64'h0,    1, 32'd2, 64'h4,   0, 64'h8);
        vecs[5]  = mk(1, 1, 0, 64'h0,    1, 32'd2, 64'h4,   0, 64'h8);
        vecs[6]  = mk(1, 0, 0, 64'h0,    1, 32'd3, 64'h8,   0, 64'hC);
        vecs[7]  = mk(1, 0, 0, 64'h0,    1, 32'd4, 64'hC,   0, 64'h10);
        vecs[8]  = mk(1, 1, 1, 64'h43,   0, NOP,   64'h0,   0, 64'h40);
        vecs[9]  = mk(1, 0, 0, 64'h0,    1, 32'd17, 64'h40, 0, 64'h44);
        vecs[10] = mk(1, 0, 1, 64'h800,  0, NOP,   64'h0,   1, 64'h800);
        vecs[11] = mk(1, 0, 0, 64'h0,    0, NOP,   64'h0,   1, 64'h800);
        vecs[12] = mk(1, 1, 0, 64'h0,    0, NOP,   64'h0,   1, 64'h800);
        vecs[13] = mk(1, 0, 1, 64'h3FE,  0, NOP,   64'h0,   0, 64'h3FC);
        vecs[14] = mk(1, 0, 0, 64'h0,    1, 32'd256, 64'h3FC, 1, 64'h400);
        vecs[15] = mk(1, 0, 0, 64'h0,    0, NOP,   64'h0,   1, 64'h400);
        vecs[16] = mk(1, 0, 1, 64'h10,   0, NOP,   64'h0,   0, 64'h10);
        vecs[17] = mk(1, 0, 0, 64'h0,    1, 32'd5, 64'h10,  0, 64'h14);
        vecs[18] = mk(0, 0, 1, 64'h80,   0, NOP,   64'h0,   0, 64'h0);
        vecs[19] = mk(1, 0, 0, 64'h0,    1, 32'd1, 64'h0,   0, 64'h4);

        for (int i = 0; i < NVEC; i++) begin
            applyStimulus(vecs[i].rst_n, vecs[i].stall, vecs[i].redirect, vecs[i].rpc);
            checkOutput($sformatf("vec%0d", i), vecs[i].e_valid, vecs[i].e_instr,
                        vecs[i].e_pc, vecs[i].e_halted, vecs[i].e_addr);
        end

        // Reset fields that the table does not cover for bubbles.
        applyStimulus(1'b0, 1'b0, 1'b0, 64'h0);
        checkField("reset.pc", if_id_pc, 64'h0);
        checkField("reset.pc_plus4", if_id_pc_plus4, 64'h0);

        // Straight run from reset to the last ROM word and off the end.
        for (int k = 1; k <= 256; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
            checkField($sformatf("run%0d.valid", k), 64'(if_id_valid), 64'd1);
            checkField($sformatf("run%0d.pc", k), if_id_pc, 64'(4 * (k - 1)));
            checkField($sformatf("run%0d.instr", k), 64'(if_id_instr), 64'(k));
        end
        checkField("run_end.halted", 64'(halted), 64'd1);
        checkField("run_end.imem_addr", imem_addr, 64'd1024);
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
            checkOutput($sformatf("halt%0d", k), 1'b0, NOP, 64'h0, 1'b1, 64'd1024);
        end

        // Redirect out of HALTED, then reset in the middle of a stalled redirect.
        applyStimulus(1'b1, 1'b0, 1'b1, 64'h10);
        checkOutput("exit_halt", 1'b0, NOP, 64'h0, 1'b0, 64'h10);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("exit_halt_fetch", 1'b1, 32'd5, 64'h10, 1'b0, 64'h14);
        applyStimulus(1'b0, 1'b1, 1'b1, 64'h200);
        checkOutput("reset_wins", 1'b0, NOP, 64'h0, 1'b0, 64'h0);
        applyStimulus(1'b1, 1'b0, 1'b0, 64'h0);
        checkOutput("after_reset", 1'b1, 32'd1, 64'h0, 1'b0, 64'h4);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the pipelined CPU. Holds the program counter, drives the combinational instruction ROM address, and captures the returned instruction into the IF/ID pipeline register. Handles stalls from hazard logic, redirects from resolved branches, and halts fetch cleanly when the PC leaves the ROM.

## Interface
- IMEM_SIZE, 1024: ROM size in bytes; power of two, greater than 4; must match the ROM instance.
- RESET_PC, 64'd0: PC value after reset; word-aligned.
- clk  in  1  single clock; all state updates on posedge.
- reset_n  in  1  synchronous, active-low reset, sampled on posedge clk.
- imem_addr  out  64  byte address to the instruction ROM; equals the PC register.
- imem_instr  in  32  combinational ROM read data for imem_addr.
- stall_i  in  1  hold the PC and IF/ID contents this cycle.
- redirect_i  in  1  a taken branch or jump has been resolved downstream.
- redirect_pc  in  64  target address; bits [1:0] are ignored and treated as 0.
- if_id_valid  out  1  the IF/ID register holds a real instruction.
- if_id_instr  out  32  fetched instruction, or NOP_INSTR when the slot is a bubble.
- if_id_pc  out  64  address of if_id_instr.
- if_id_pc_plus4  out  64  if_id_pc + 4, used by BL.
- halted  out  1  fetch has stopped because the PC is out of ROM bounds.

## Operation
- States: FETCH and HALTED.
- Event priority each cycle: reset > redirect > stall > sequential advance.
- Reset (reset_n=0 at posedge):
  - PC becomes RESET_PC; state becomes FETCH.
  - if_id_valid=0, if_id_instr=NOP_INSTR (32'hD503201F), if_id_pc=0, if_id_pc_plus4=0, halted=0.
  - Reset asserted mid-stall or mid-redirect is handled identically.
- Redirect (any state):
  - PC becomes {redirect_pc[63:2],2'b00}.
  - IF/ID is loaded with a bubble (valid=0, NOP_INSTR), which squashes the wrong-path instruction.
  - Redirect overrides stall_i in the same cycle.
  - Next state is FETCH if the target is in bounds, otherwise HALTED.
- Stall in FETCH (no redirect): PC and all IF/ID fields hold unchanged.
- Sequential advance in FETCH:
  - IF/ID captures valid=1, imem_instr, PC, and PC+4.
  - PC becomes PC+4.
  - If the new PC is out of bounds, next state is HALTED.
- In bounds means pc <= IMEM_SIZE-4. Compare this way to avoid add overflow.
- HALTED:
  - PC holds, and IF/ID loads a bubble every non-stalled cycle.
  - halted=1.
  - Only a redirect or reset exits this state.
- If the PC is ever out of bounds in FETCH (only reachable from RESET_PC), the stage enters HALTED with no valid capture.
- PC+4 arithmetic is 64-bit modulo 2^64.

## Timing
- imem_addr is registered and changes only on posedge; the ROM read is combinational in the same cycle.
- Fetch latency: the instruction at PC appears on if_id_* one posedge after imem_addr=PC.
- The first valid IF/ID entry appears at the first posedge with reset_n=1.
- The redirect penalty is one bubble: the target instruction is valid two posedges after redirect_i is sampled.
- stall_i and redirect_i are sampled only at posedge. There are no combinational paths from them to any output.
- halted asserts in the cycle after the PC steps out of bounds. It deasserts in the cycle after an in-bounds redirect.

## Structure
- Shared package fetch_pkg:
  - NOP_INSTR constant.
  - fetch_state_t enum {FETCH, HALTED}.
  - Default IMEM_SIZE, shared with the ROM.
- Sub-module if_id_reg: the pipeline register with hold (stall) and bubble-insert (flush) controls, reusable for later stage registers.
- fetch_stage contains the PC register, the next-PC mux, bounds compare, and the state register.

## Test plan
- Reset then run 4 cycles with ROM word i = i+1: if_id_pc goes 0, 4, 8, 12, if_id_instr goes 1, 2, 3, 4, and valid=1 from the first posedge after reset.
- Stall held 3 cycles with PC=8: imem_addr stays 8, if_id_* holds unchanged, and fetch resumes at 8 then 12.
- redirect_i with redirect_pc=0x43 while stall_i=1: PC becomes 0x40, the next IF/ID is a bubble (valid=0, D503201F), then pc=0x40 is valid.
- Sequential run to PC=1020: the instruction at 1020 is captured valid, then halted=1, valid=0, and imem_addr stays at 1024.
- Redirect to 0x10 while HALTED: halted clears next cycle, and pc=0x10 is valid two posedges after the redirect.
- reset_n=0 asserted during a redirect cycle: outputs take reset values and PC=RESET_PC. Reset wins.
